// File: rtl/controle_pkg.sv
// Shared definitions for the round control unit.
// - 4-bit state encodings; the encoding doubles as the debug 7-seg value.
// - Default timeout window, in clock cycles.
package controle_pkg;

    localparam logic [3:0] INICIAL     = 4'h0;
    localparam logic [3:0] PREPARACAO  = 4'h1;
    localparam logic [3:0] ESPERA      = 4'h2;
    localparam logic [3:0] REGISTRA    = 4'h3;
    localparam logic [3:0] COMPARA     = 4'h4;
    localparam logic [3:0] PROXIMO     = 4'h5;
    localparam logic [3:0] FIM_ACERTO  = 4'hA;
    localparam logic [3:0] FIM_TIMEOUT = 4'hD;
    localparam logic [3:0] FIM_ERRO    = 4'hE;

    localparam int unsigned TIMEOUT_CICLOS_PADRAO = 3000;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one flop samples the input every cycle.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-high; clears the sample flop
//   sinal  - level input (e.g. pushbutton)
//   pulso  - high for the cycle in which sinal is 1 and was 0 on the previous edge
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinal_q <= 1'b0;
        end else begin
            sinal_q <= sinal;
        end
    end

    assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/unidade_controle_contagem.sv
// Moore control unit for the counter/comparator/7-seg datapath.
// Runs one player round: clear, then per address wait for a jogada, register the
// switches, compare, and advance; ends in success, error or timeout.
// Ports:
//   clock, reset          - clock (rising edge), asynchronous active-high reset
//   iniciar               - level; starts/restarts a round from INICIAL or a FIM state
//   jogada                - pushbutton level; only its rising edge counts
//   igual, fim            - datapath comparator equal flag and counter terminal count
//   zera, registra, conta - datapath commands
//   pronto, acertou, errou, timeout - round status
//   db_estado             - current state encoding for the debug display
module unidade_controle_contagem
    import controle_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim,
    output logic       zera,
    output logic       registra,
    output logic       conta,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int unsigned LARGURA = $clog2(TIMEOUT_CICLOS);
    localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(TIMEOUT_CICLOS - 1);

    logic [3:0]         estado_q, estado_d;
    logic [LARGURA-1:0] cnt_q, cnt_d;
    logic               jogada_pulso;

    edge_detector u_edge_jogada (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (jogada_pulso)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    // Counter only runs in ESPERA, so every entry into ESPERA opens a fresh window.
    always_comb begin
        cnt_d = '0;
        if (estado_q == ESPERA) begin
            cnt_d = cnt_q + LARGURA'(1);
        end
    end

    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:    estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: estado_d = ESPERA;
            ESPERA: begin
                // A jogada in the terminal-count cycle still wins over the timeout.
                if (jogada_pulso) begin
                    estado_d = REGISTRA;
                end else if (cnt_q == ULTIMO) begin
                    estado_d = FIM_TIMEOUT;
                end else begin
                    estado_d = ESPERA;
                end
            end
            REGISTRA:   estado_d = COMPARA;
            COMPARA: begin
                if (!igual) begin
                    estado_d = FIM_ERRO;
                end else if (fim) begin
                    estado_d = FIM_ACERTO;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO:    estado_d = ESPERA;
            FIM_ACERTO: estado_d = iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:   estado_d = iniciar ? PREPARACAO : FIM_ERRO;
            FIM_TIMEOUT: estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:    estado_d = INICIAL;
        endcase
    end

    // Outputs decode the state register only, so the asynchronous reset clears them at once.
    always_comb begin
        zera     = 1'b0;
        registra = 1'b0;
        conta    = 1'b0;
        pronto   = 1'b0;
        acertou  = 1'b0;
        errou    = 1'b0;
        timeout  = 1'b0;
        case (estado_q)
            PREPARACAO:  zera = 1'b1;
            REGISTRA:    registra = 1'b1;
            PROXIMO:     conta = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_contagem.sv
// Directed testbench for unidade_controle_contagem with an 8-cycle timeout window.
module tb_unidade_controle_contagem;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fim;
    logic       zera;
    logic       registra;
    logic       conta;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;
    logic [6:0] saidas;

    int n_tests;
    int n_fail;
    int n_zera;
    int n_registra;
    int n_conta;
    logic [3:0] trace[$];

    // {zera, registra, conta, pronto, acertou, errou, timeout}
    assign saidas = {zera, registra, conta, pronto, acertou, errou, timeout};

    localparam logic [3:0] EXP_WIN [17] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h2, 4'h3, 4'h4,
                                            4'h5, 4'h2, 4'h3, 4'h4, 4'h5, 4'h2, 4'h3, 4'h4,
                                            4'hA};

    unidade_controle_contagem #(
        .TIMEOUT_CICLOS (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fim       (fim),
        .zera      (zera),
        .registra  (registra),
        .conta     (conta),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock, settle 1 time unit past the edge, and log what the state shows.
    task automatic ciclo();
        @(posedge clock);
        #1;
        trace.push_back(db_estado);
        if (zera) n_zera++;
        if (registra) n_registra++;
        if (conta) n_conta++;
    endtask

    task automatic limpa_contagens();
        n_zera = 0;
        n_registra = 0;
        n_conta = 0;
        trace.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        iniciar = 1'b0;
        jogada = 1'b0;
        igual = 1'b0;
        fim = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_tests++;
        if (db_estado !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_estado: got %h expected 0", db_estado);
        end
        n_tests++;
        if (saidas !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_saidas: got %b expected 0000000", saidas);
        end
        reset = 1'b0;
        ciclo();
        n_tests++;
        if (db_estado !== 4'h0) begin
            n_fail++;
            $display("FAIL idle_sem_iniciar: got %h expected 0", db_estado);
        end
    endtask

    task automatic test_full_win();
        limpa_contagens();
        iniciar = 1'b1;
        ciclo();
        iniciar = 1'b0;
        ciclo();
        for (int k = 0; k < 4; k++) begin
            igual = 1'b1;
            fim = (k == 3);
            jogada = 1'b1;
            ciclo();
            n_tests++;
            if (registra !== 1'b1) begin
                n_fail++;
                $display("FAIL win_latencia_registra[%0d]: got %b expected 1", k, registra);
            end
            jogada = 1'b0;
            ciclo();
            ciclo();
            if (k < 3) ciclo();
        end
        fim = 1'b0;
        n_tests++;
        if (trace.size() != 17) begin
            n_fail++;
            $display("FAIL win_trace_len: got %0d expected 17", trace.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                n_tests++;
                if (trace[i] !== EXP_WIN[i]) begin
                    n_fail++;
                    $display("FAIL win_trace[%0d]: got %h expected %h", i, trace[i], EXP_WIN[i]);
                end
            end
        end
        n_tests++;
        if (n_zera != 1 || n_conta != 3 || n_registra != 4) begin
            n_fail++;
            $display("FAIL win_pulsos: zera/conta/registra got %0d/%0d/%0d expected 1/3/4",
                     n_zera, n_conta, n_registra);
        end
        n_tests++;
        if (db_estado !== 4'hA || saidas !== 7'b0001100) begin
            n_fail++;
            $display("FAIL win_fim: got estado %h saidas %b expected A 0001100", db_estado, saidas);
        end
    endtask

    task automatic test_error();
        limpa_contagens();
        iniciar = 1'b1;
        ciclo();
        iniciar = 1'b0;
        ciclo();
        igual = 1'b1;
        fim = 1'b0;
        jogada = 1'b1;
        ciclo();
        jogada = 1'b0;
        ciclo();
        ciclo();
        ciclo();
        igual = 1'b0;
        jogada = 1'b1;
        ciclo();
        jogada = 1'b0;
        ciclo();
        ciclo();
        n_tests++;
        if (db_estado !== 4'hE || saidas !== 7'b0001010) begin
            n_fail++;
            $display("FAIL erro_fim: got estado %h saidas %b expected E 0001010", db_estado, saidas);
        end
        n_tests++;
        if (n_conta != 1) begin
            n_fail++;
            $display("FAIL erro_conta: got %0d expected 1", n_conta);
        end
        iniciar = 1'b1;
        ciclo();
        iniciar = 1'b0;
        n_tests++;
        if (db_estado !== 4'h1 || zera !== 1'b1) begin
            n_fail++;
            $display("FAIL erro_reinicio: got estado %h zera %b expected 1 1", db_estado, zera);
        end
    endtask

    task automatic test_timeout();
        int n_espera;
        igual = 1'b0;
        fim = 1'b0;
        jogada = 1'b0;
        ciclo();
        n_espera = 0;
        while (db_estado == 4'h2 && n_espera < 20) begin
            n_espera++;
            ciclo();
        end
        n_tests++;
        if (n_espera != 8) begin
            n_fail++;
            $display("FAIL timeout_ciclos: got %0d expected 8", n_espera);
        end
        n_tests++;
        if (db_estado !== 4'hD || saidas !== 7'b0001001) begin
            n_fail++;
            $display("FAIL timeout_fim: got estado %h saidas %b expected D 0001001",
                     db_estado, saidas);
        end
        // Variant: rising edge in the 8th ESPERA cycle beats the timeout.
        iniciar = 1'b1;
        ciclo();
        iniciar = 1'b0;
        ciclo();
        repeat (7) ciclo();
        n_tests++;
        if (db_estado !== 4'h2) begin
            n_fail++;
            $display("FAIL timeout_ciclo8_espera: got %h expected 2", db_estado);
        end
        jogada = 1'b1;
        ciclo();
        n_tests++;
        if (db_estado !== 4'h3) begin
            n_fail++;
            $display("FAIL timeout_jogada_vence: got %h expected 3", db_estado);
        end
        jogada = 1'b0;
        ciclo();
        ciclo();
    endtask

    task automatic test_held_button();
        int n_espera;
        iniciar = 1'b1;
        ciclo();
        iniciar = 1'b0;
        ciclo();
        limpa_contagens();
        igual = 1'b1;
        fim = 1'b0;
        jogada = 1'b1;
        repeat (20) ciclo();
        jogada = 1'b0;
        n_espera = 0;
        foreach (trace[i]) if (trace[i] == 4'h2) n_espera++;
        n_tests++;
        if (n_registra != 1) begin
            n_fail++;
            $display("FAIL held_registra: got %0d expected 1", n_registra);
        end
        n_tests++;
        if (trace[0] !== 4'h3 || trace[3] !== 4'h2 || n_espera != 8) begin
            n_fail++;
            $display("FAIL held_espera: got first %h fourth %h espera %0d expected 3 2 8",
                     trace[0], trace[3], n_espera);
        end
        n_tests++;
        if (db_estado !== 4'hD) begin
            n_fail++;
            $display("FAIL held_fim: got %h expected D", db_estado);
        end
    endtask

    task automatic test_reset_mid();
        iniciar = 1'b1;
        ciclo();
        iniciar = 1'b0;
        ciclo();
        ciclo();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (db_estado !== 4'h0 || saidas !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_espera_async: got estado %h saidas %b expected 0 0000000",
                     db_estado, saidas);
        end
        iniciar = 1'b1;
        jogada = 1'b1;
        ciclo();
        ciclo();
        n_tests++;
        if (db_estado !== 4'h0 || saidas !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mantido: got estado %h saidas %b expected 0 0000000",
                     db_estado, saidas);
        end
        reset = 1'b0;
        iniciar = 1'b0;
        jogada = 1'b0;
        ciclo();
        // Reach a FIM state so that asserted outputs can be seen dropping.
        iniciar = 1'b1;
        ciclo();
        iniciar = 1'b0;
        repeat (9) ciclo();
        n_tests++;
        if (db_estado !== 4'hD || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prep_timeout: got estado %h timeout %b expected D 1",
                     db_estado, timeout);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (db_estado !== 4'h0 || saidas !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_fim_async: got estado %h saidas %b expected 0 0000000",
                     db_estado, saidas);
        end
        ciclo();
        reset = 1'b0;
        ciclo();
    endtask

    task automatic test_illegal();
        iniciar = 1'b1;
        ciclo();
        iniciar = 1'b0;
        ciclo();
        force dut.estado_q = 4'h7;
        #1;
        release dut.estado_q;
        #1;
        n_tests++;
        if (db_estado !== 4'h7 || saidas !== 7'b0) begin
            n_fail++;
            $display("FAIL ilegal_forcado: got estado %h saidas %b expected 7 0000000",
                     db_estado, saidas);
        end
        ciclo();
        n_tests++;
        if (db_estado !== 4'h0 || saidas !== 7'b0) begin
            n_fail++;
            $display("FAIL ilegal_recupera: got estado %h saidas %b expected 0 0000000",
                     db_estado, saidas);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        limpa_contagens();
        test_reset();
        test_full_win();
        test_error();
        test_timeout();
        test_held_button();
        test_reset_mid();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
